lot_sched: RTL and testbench
============================

LOT_SCHED -- requirements
Module: lot_sched

Interface
REQ-001 SHALL have one clock and a reset that is synchronous and active-high, named as follows:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.

REQ-002 SHALL have the following data and control ports:
- num  in  4  bet digit.
- insere  in  1  digit-valid strobe, one digit per cycle.
- fim  in  1  close bet entry.
- fim_jogo  in  1  start draw evaluation.
- ev_start  out  1  one-cycle request to the shared prize evaluator.
- ev_bet  out  20  bet presented to the evaluator, 5 digits, MSD in [19:16].
- ev_done  in  1  evaluator result valid.
- ev_prize  in  2  prize class: 0 none, 1..3.
- state  out  4  FSM state code.
- bet_count  out  3  stored bets, 0..4.
- full  out  1  bet buffer holds 4 bets.
- cnt_p1, cnt_p2, cnt_p3  out  3 each  prize-class tallies.
- led15  out  1  at least one prize won in the last round.
- tmo  out  1  sticky: an evaluation timed out.
- err  out  1  one-cycle pulse on a rejected digit.

Function
REQ-003 SHALL implement these states and codes: IDLE=0, ENTRY=1, CLOSED=2, EVAL_REQ=3, EVAL_WAIT=4, DONE=5.
- Codes 6..15 are unreachable and SHALL return to IDLE.

REQ-004 IDLE: insere=1 SHALL go to ENTRY and capture that digit as digit 0.
- Capturing the first digit of a round SHALL also clear cnt_p1..3, led15, tmo and bet_count.

REQ-005 ENTRY: each insere=1 cycle SHALL shift num into a 20-bit bet register and increment a digit counter 0..4.

REQ-006 The 5th digit SHALL be written to buffer slot bet_count.
- bet_count increments on the following edge.
- The digit counter wraps to 0.

REQ-007 With full=1, insere SHALL be ignored with no state change.

REQ-008 fim in ENTRY SHALL discard any partial bet (1..4 digits).
- If bet_count=0, it SHALL go to IDLE.
- Otherwise it SHALL go to CLOSED.

REQ-009 insere and fim asserted in the same cycle: fim SHALL win and the digit SHALL be dropped.

REQ-010 fim_jogo SHALL be acted on only in CLOSED; there it SHALL go to EVAL_REQ with index 0. fim_jogo is ignored in every other state.

REQ-011 EVAL_REQ SHALL assert ev_start for exactly one cycle with ev_bet=buffer[index], then go to EVAL_WAIT.

REQ-012 EVAL_WAIT: on ev_done=1, the block SHALL increment cnt_pN for ev_prize=N (no increment for 0) and set led15 if N≠0.
- If index=bet_count-1, it SHALL go to DONE.
- Otherwise it SHALL increment index and go to EVAL_REQ.

REQ-013 If ev_done is not seen within 16 cycles of ev_start, the block SHALL:
- set tmo;
- count the bet as prize 0;
- advance exactly as in REQ-012.

REQ-014 ev_done arriving outside EVAL_WAIT SHALL be ignored.

REQ-015 DONE SHALL last one cycle, then go to IDLE.
- Tallies, led15, tmo and bet_count SHALL hold until the first digit of the next round.

REQ-016 Latency: from the fim_jogo edge to the first ev_start SHALL be exactly 1 cycle.

REQ-017 Outputs SHALL be registered.
- full = (bet_count==4).
- ev_bet = 0 when ev_start=0.

Reset
REQ-018 reset=1 at a clock edge SHALL force IDLE from any state, including mid-entry and mid-evaluation.

REQ-019 Reset SHALL clear bet_count, digit counter, index, timeout counter, cnt_p1..3, led15, tmo, err, ev_start, ev_bet and the buffer to 0.
- ev_start SHALL be 0 in the cycle following reset.

Configuration
REQ-020 Macro LOT_DIGIT_CHECK_EN:
- When defined, a digit with num>9 under insere=1 SHALL be ignored (no shift, no count) and SHALL pulse err for 1 cycle.
- When undefined, all 16 values SHALL be accepted and err SHALL be tied to 0.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset, enter 4,7,0,1,0, fim, fim_jogo, evaluator returns prize 1 after 3 cycles -> one ev_start with ev_bet=0x47010, cnt_p1=1, led15=1, state passes 3,4,5,0.
- Enter 6,7,0,3,9 / 4,7,0,2,9 / 2,3,1,1,9, fim, fim_jogo, evaluator returns 2,1,0 -> 3 ev_start pulses in buffer order, cnt_p1=1, cnt_p2=1, cnt_p3=0.
- Enter 5 full bets -> bet_count=4, full=1, 5th bet ignored; fim after 2 digits of a new bet -> partial bet dropped, state=2.
- Evaluator never responds -> tmo=1 after 16 cycles, bet counted as prize 0, then DONE.
- Reset asserted during EVAL_WAIT -> next cycle state=0, all tallies 0, ev_start=0.
- With LOT_DIGIT_CHECK_EN defined, insere with num=0xA -> err pulse, digit counter unchanged.

Source files
------------

// File: rtl/lot_sched.sv
// rtl/lot_sched.sv - lottery bet entry and prize evaluation scheduler
//
// Collects up to four 5-digit bets, then hands them one at a time to a
// shared prize evaluator and tallies the prize classes it returns.
// Optional macro: LOT_DIGIT_CHECK_EN (reject digits above 9, pulse err).
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   num, insere           bet digit and its valid strobe
//   fim                   close bet entry
//   fim_jogo              start draw evaluation (only in CLOSED)
//   ev_start, ev_bet      one-cycle evaluator request and the bet (MSD [19:16])
//   ev_done, ev_prize     evaluator result valid and prize class 0..3
//   state                 FSM state code
//   bet_count, full       stored bets 0..4, buffer full flag
//   cnt_p1..cnt_p3        prize-class tallies
//   led15                 at least one prize won in the last round
//   tmo                   sticky evaluator timeout
//   err                   one-cycle pulse on a rejected digit
module lot_sched (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  num,
  input  logic        insere,
  input  logic        fim,
  input  logic        fim_jogo,
  output logic        ev_start,
  output logic [19:0] ev_bet,
  input  logic        ev_done,
  input  logic [1:0]  ev_prize,
  output logic [3:0]  state,
  output logic [2:0]  bet_count,
  output logic        full,
  output logic [2:0]  cnt_p1,
  output logic [2:0]  cnt_p2,
  output logic [2:0]  cnt_p3,
  output logic        led15,
  output logic        tmo,
  output logic        err
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ENTRY     = 4'd1,
    S_CLOSED    = 4'd2,
    S_EVAL_REQ  = 4'd3,
    S_EVAL_WAIT = 4'd4,
    S_DONE      = 4'd5
  } st_t;

  st_t         st;
  logic [19:0] bet_reg;
  logic [2:0]  dcnt;
  logic [19:0] buf_q [0:3];
  logic [1:0]  idx;
  logic [3:0]  tcnt;
  logic        digit_ok;
  logic        resolve;
  logic        last;
  logic [19:0] bet_next;

  assign state    = st;
  assign bet_next = {bet_reg[15:0], num};
  // A wait ends on a result, or on the 16th wait edge without one.
  assign resolve  = ev_done || (tcnt == 4'd15);
  assign last     = (({1'b0, idx}) + 3'd1) == bet_count;

`ifdef LOT_DIGIT_CHECK_EN
  logic accept_try;

  assign digit_ok   = (num <= 4'd9);
  // Only digits that would otherwise be taken can be rejected.
  assign accept_try = insere &&
                      ((st == S_IDLE) || ((st == S_ENTRY) && !fim && !full));

  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= accept_try && !digit_ok;
  end
`else
  assign digit_ok = 1'b1;
  assign err      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      st        <= S_IDLE;
      bet_reg   <= 20'd0;
      dcnt      <= 3'd0;
      idx       <= 2'd0;
      tcnt      <= 4'd0;
      bet_count <= 3'd0;
      full      <= 1'b0;
      cnt_p1    <= 3'd0;
      cnt_p2    <= 3'd0;
      cnt_p3    <= 3'd0;
      led15     <= 1'b0;
      tmo       <= 1'b0;
      ev_start  <= 1'b0;
      ev_bet    <= 20'd0;
      for (int i = 0; i < 4; i++) buf_q[i] <= 20'd0;
    end else begin
      ev_start <= 1'b0;
      ev_bet   <= 20'd0;
      case (st)
        S_IDLE: begin
          // First digit of a round also wipes the previous round's results.
          if (insere && digit_ok) begin
            st        <= S_ENTRY;
            bet_reg   <= {16'd0, num};
            dcnt      <= 3'd1;
            bet_count <= 3'd0;
            full      <= 1'b0;
            cnt_p1    <= 3'd0;
            cnt_p2    <= 3'd0;
            cnt_p3    <= 3'd0;
            led15     <= 1'b0;
            tmo       <= 1'b0;
          end
        end
        S_ENTRY: begin
          if (fim) begin
            // Partial bet is dropped; a digit in the same cycle is lost too.
            dcnt    <= 3'd0;
            bet_reg <= 20'd0;
            st      <= (bet_count == 3'd0) ? S_IDLE : S_CLOSED;
          end else if (insere && !full && digit_ok) begin
            if (dcnt == 3'd4) begin
              buf_q[bet_count[1:0]] <= bet_next;
              bet_count             <= bet_count + 3'd1;
              full                  <= (bet_count == 3'd3);
              dcnt                  <= 3'd0;
              bet_reg               <= 20'd0;
            end else begin
              bet_reg <= bet_next;
              dcnt    <= dcnt + 3'd1;
            end
          end
        end
        S_CLOSED: begin
          if (fim_jogo) begin
            idx <= 2'd0;
            st  <= S_EVAL_REQ;
          end
        end
        S_EVAL_REQ: begin
          ev_start <= 1'b1;
          ev_bet   <= buf_q[idx];
          tcnt     <= 4'd0;
          st       <= S_EVAL_WAIT;
        end
        S_EVAL_WAIT: begin
          if (resolve) begin
            if (ev_done) begin
              case (ev_prize)
                2'd1:    cnt_p1 <= cnt_p1 + 3'd1;
                2'd2:    cnt_p2 <= cnt_p2 + 3'd1;
                2'd3:    cnt_p3 <= cnt_p3 + 3'd1;
                default: ;
              endcase
              if (ev_prize != 2'd0) led15 <= 1'b1;
            end else begin
              tmo <= 1'b1;
            end
            if (last) begin
              st <= S_DONE;
            end else begin
              idx <= idx + 2'd1;
              st  <= S_EVAL_REQ;
            end
          end else begin
            tcnt <= tcnt + 4'd1;
          end
        end
        S_DONE:  st <= S_IDLE;
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lot_sched.sv
// tb/tb_lot_sched.sv - scoreboard testbench for lot_sched
module tb_lot_sched;

  logic        clk;
  logic        reset;
  logic [3:0]  num;
  logic        insere;
  logic        fim;
  logic        fim_jogo;
  logic        ev_start;
  logic [19:0] ev_bet;
  logic        ev_done;
  logic [1:0]  ev_prize;
  logic [3:0]  state;
  logic [2:0]  bet_count;
  logic        full;
  logic [2:0]  cnt_p1;
  logic [2:0]  cnt_p2;
  logic [2:0]  cnt_p3;
  logic        led15;
  logic        tmo;
  logic        err;

  int checks;
  int failures;

  logic [19:0] exp_q [$];
  int          resp_delay [$];
  int          resp_prize [$];
  int          rd;
  int          rp;
  logic [19:0] mexp;

  lot_sched dut (
    .clk(clk), .reset(reset), .num(num), .insere(insere), .fim(fim),
    .fim_jogo(fim_jogo), .ev_start(ev_start), .ev_bet(ev_bet),
    .ev_done(ev_done), .ev_prize(ev_prize), .state(state),
    .bet_count(bet_count), .full(full), .cnt_p1(cnt_p1), .cnt_p2(cnt_p2),
    .cnt_p3(cnt_p3), .led15(led15), .tmo(tmo), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dig(input logic [3:0] d);
    num    = d;
    insere = 1'b1;
    tick();
    insere = 1'b0;
  endtask

  task automatic bet5(input logic [19:0] b);
    for (int i = 0; i < 5; i++) dig(b[19-4*i -: 4]);
  endtask

  task automatic pulse_fim();
    fim = 1'b1;
    tick();
    fim = 1'b0;
  endtask

  task automatic pulse_fim_jogo();
    fim_jogo = 1'b1;
    tick();
    fim_jogo = 1'b0;
  endtask

  task automatic expect_bet(input logic [19:0] b, input int d, input int p);
    exp_q.push_back(b);
    resp_delay.push_back(d);
    resp_prize.push_back(p);
  endtask

  task automatic wait_state(input logic [3:0] s, input int lim, input string nm);
    int n;
    n = 0;
    while (state !== s && n < lim) begin
      tick();
      n++;
    end
    check(nm, {28'd0, state}, {28'd0, s});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    num      = 4'd0;
    insere   = 1'b0;
    fim      = 1'b0;
    fim_jogo = 1'b0;
    ev_done  = 1'b0;
    ev_prize = 2'd0;

    fork
      // Monitor: every ev_start pulse must carry the next expected bet.
      forever begin
        @(negedge clk);
        if (!reset && ev_start === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL ev_start_unexpected actual=%0h required=none", ev_bet);
          end else begin
            mexp = exp_q.pop_front();
            check("ev_bet", {12'd0, ev_bet}, {12'd0, mexp});
          end
        end
      end
      // Evaluator model: answers each request after rd cycles, or never if rd<0.
      forever begin
        @(negedge clk);
        if (ev_start === 1'b1 && resp_delay.size() > 0) begin
          rd = resp_delay.pop_front();
          rp = resp_prize.pop_front();
          if (rd > 0) begin
            repeat (rd - 1) @(posedge clk);
            #1;
            ev_done  = 1'b1;
            ev_prize = rp[1:0];
            @(posedge clk);
            #1;
            ev_done  = 1'b0;
            ev_prize = 2'd0;
          end
        end
      end
    join_none

    tick();
    tick();
    reset = 1'b0;
    check("rst_state", {28'd0, state}, 32'd0);
    check("rst_bet_count", {29'd0, bet_count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_ev_start", {31'd0, ev_start}, 32'd0);
    check("rst_ev_bet", {12'd0, ev_bet}, 32'd0);
    check("rst_tallies", {23'd0, cnt_p1, cnt_p2, cnt_p3}, 32'd0);
    check("rst_flags", {29'd0, led15, tmo, err}, 32'd0);

    // Single bet, prize 1 after 3 cycles, exact state sequence.
    bet5(20'h47010);
    check("s1_bet_count", {29'd0, bet_count}, 32'd1);
    pulse_fim();
    check("s1_closed", {28'd0, state}, 32'd2);
    expect_bet(20'h47010, 3, 1);
    pulse_fim_jogo();
    check("s1_state_req", {28'd0, state}, 32'd3);
    check("s1_no_early_start", {31'd0, ev_start}, 32'd0);
    tick();
    check("s1_state_wait", {28'd0, state}, 32'd4);
    check("s1_latency_start", {31'd0, ev_start}, 32'd1);
    tick();
    check("s1_start_one_cycle", {31'd0, ev_start}, 32'd0);
    check("s1_ev_bet_zero", {12'd0, ev_bet}, 32'd0);
    tick();
    check("s1_still_wait", {28'd0, state}, 32'd4);
    tick();
    check("s1_state_done", {28'd0, state}, 32'd5);
    check("s1_cnt_p1", {29'd0, cnt_p1}, 32'd1);
    check("s1_led15", {31'd0, led15}, 32'd1);
    tick();
    check("s1_state_idle", {28'd0, state}, 32'd0);
    check("s1_cnt_hold", {29'd0, cnt_p1}, 32'd1);

    // Three bets, prizes 2,1,0 in buffer order.
    dig(4'h6);
    check("s2_first_digit_clears", {22'd0, cnt_p1, led15, bet_count, state}, {22'd0, 3'd0, 1'b0, 3'd0, 4'd1});
    dig(4'h7); dig(4'h0); dig(4'h3); dig(4'h9);
    bet5(20'h47029);
    bet5(20'h23119);
    check("s2_bet_count", {29'd0, bet_count}, 32'd3);
    pulse_fim();
    expect_bet(20'h67039, 2, 2);
    expect_bet(20'h47029, 5, 1);
    expect_bet(20'h23119, 1, 0);
    pulse_fim_jogo();
    wait_state(4'd5, 200, "s2_reach_done");
    check("s2_tallies", {23'd0, cnt_p1, cnt_p2, cnt_p3}, {23'd0, 3'd1, 3'd1, 3'd0});
    check("s2_flags", {30'd0, led15, tmo}, {30'd0, 1'b1, 1'b0});
    tick();
    check("s2_idle", {28'd0, state}, 32'd0);
    check("s2_all_sent", exp_q.size(), 32'd0);

    // Buffer full: fifth bet ignored.
    bet5(20'h11111);
    bet5(20'h22222);
    bet5(20'h33333);
    check("s3_three_not_full", {28'd0, full, bet_count}, {28'd0, 1'b0, 3'd3});
    bet5(20'h44444);
    check("s3_four_full", {28'd0, full, bet_count}, {28'd0, 1'b1, 3'd4});
    bet5(20'h55555);
    check("s3_fifth_ignored", {25'd0, bet_count, state}, {25'd0, 3'd4, 4'd1});
    pulse_fim();
    check("s3_closed", {28'd0, state}, 32'd2);
    expect_bet(20'h11111, 1, 3);
    expect_bet(20'h22222, 1, 3);
    expect_bet(20'h33333, 1, 1);
    expect_bet(20'h44444, 1, 0);
    pulse_fim_jogo();
    wait_state(4'd5, 200, "s3_reach_done");
    check("s3_tallies", {23'd0, cnt_p1, cnt_p2, cnt_p3}, {23'd0, 3'd1, 3'd0, 3'd2});
    tick();
    check("s3_hold_after_done", {27'd0, full, bet_count, state}, {27'd0, 1'b1, 3'd4, 4'd0});

    // fim with only a partial bet and no complete ones returns to IDLE.
    dig(4'h1);
    dig(4'h2);
    pulse_fim();
    check("s4_fim_empty_idle", {25'd0, bet_count, state}, {25'd0, 3'd0, 4'd0});

    // Partial bet dropped; fim_jogo ignored in ENTRY; fim beats insere.
    bet5(20'h98765);
    dig(4'h1);
    dig(4'h2);
    pulse_fim_jogo();
    check("s5_fim_jogo_ignored", {28'd0, state}, 32'd1);
    num    = 4'h3;
    insere = 1'b1;
    fim    = 1'b1;
    tick();
    insere = 1'b0;
    fim    = 1'b0;
    check("s5_partial_dropped", {25'd0, bet_count, state}, {25'd0, 3'd1, 4'd2});
    expect_bet(20'h98765, 2, 0);
    pulse_fim_jogo();
    wait_state(4'd5, 200, "s5_reach_done");
    check("s5_prize0", {20'd0, cnt_p1, cnt_p2, cnt_p3, led15, tmo}, 32'd0);
    tick();

    // Evaluator silent: timeout on the 16th wait cycle.
    bet5(20'h13579);
    pulse_fim();
    expect_bet(20'h13579, -1, 0);
    pulse_fim_jogo();
    tick();
    check("s6_wait", {28'd0, state}, 32'd4);
    repeat (15) tick();
    check("s6_no_tmo_yet", {27'd0, tmo, state}, {27'd0, 1'b0, 4'd4});
    tick();
    check("s6_tmo_done", {27'd0, tmo, state}, {27'd0, 1'b1, 4'd5});
    check("s6_counted_prize0", {22'd0, cnt_p1, cnt_p2, cnt_p3, led15}, 32'd0);
    tick();
    check("s6_idle_tmo_hold", {27'd0, tmo, state}, {27'd0, 1'b1, 4'd0});

    // Reset while waiting on the evaluator.
    bet5(20'h24680);
    bet5(20'h11223);
    pulse_fim();
    expect_bet(20'h24680, 2, 1);
    expect_bet(20'h11223, -1, 0);
    pulse_fim_jogo();
    repeat (4) tick();
    check("s7_second_wait", {25'd0, cnt_p1, state}, {25'd0, 3'd1, 4'd4});
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("s7_rst_state", {28'd0, state}, 32'd0);
    check("s7_rst_tallies", {21'd0, cnt_p1, cnt_p2, cnt_p3, led15, tmo}, 32'd0);
    check("s7_rst_outputs", {8'd0, ev_start, ev_bet, bet_count}, 32'd0);
    check("s7_all_sent", exp_q.size(), 32'd0);

    // Digit range check.
    dig(4'h1);
    num    = 4'hA;
    insere = 1'b1;
    tick();
    insere = 1'b0;
`ifdef LOT_DIGIT_CHECK_EN
    check("s8_err_pulse", {31'd0, err}, 32'd1);
    tick();
    check("s8_err_clear", {31'd0, err}, 32'd0);
    dig(4'h2); dig(4'h3); dig(4'h4);
    check("s8_digit_not_counted", {29'd0, bet_count}, 32'd0);
    dig(4'h5);
    check("s8_bet_complete", {29'd0, bet_count}, 32'd1);
`else
    check("s8_err_tied", {31'd0, err}, 32'd0);
    dig(4'h2); dig(4'h3);
    check("s8_hex_digit_counted", {29'd0, bet_count}, 32'd0);
    dig(4'h4);
    check("s8_bet_complete", {29'd0, bet_count}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
